// File: rtl/fir_coef_loader_if.sv
// Reload and config AXI-Stream channels toward the FIR compiler.
// The master side is the loader; the slave side is the FIR core.
interface fir_coef_loader_if #(
   parameter int W = 24
);
   logic         m_axis_reload_tvalid;
   logic         m_axis_reload_tready;
   logic         m_axis_reload_tlast;
   logic [W-1:0] m_axis_reload_tdata;
   logic         m_axis_config_tvalid;
   logic         m_axis_config_tready;
   logic [7:0]   m_axis_config_tdata;

   modport master (
      output m_axis_reload_tvalid,
      input  m_axis_reload_tready,
      output m_axis_reload_tlast,
      output m_axis_reload_tdata,
      output m_axis_config_tvalid,
      input  m_axis_config_tready,
      output m_axis_config_tdata
   );

   modport slave (
      input  m_axis_reload_tvalid,
      output m_axis_reload_tready,
      input  m_axis_reload_tlast,
      input  m_axis_reload_tdata,
      input  m_axis_config_tvalid,
      output m_axis_config_tready,
      input  m_axis_config_tdata
   );
endinterface

// File: rtl/fir_coef_loader.sv
// Coefficient buffer that streams a full tap set into a FIR reload
// port, then commits it with a single config packet.
module fir_coef_loader #(
   parameter int C_RELOAD_TDATA_WIDTH = 24,
   parameter int C_NUM_TAPS           = 63,
   parameter int C_ADDR_WIDTH         = 6
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic                            cfg_we,
   input  logic [C_ADDR_WIDTH-1:0]         cfg_addr,
   input  logic [C_RELOAD_TDATA_WIDTH-1:0] cfg_wdata,
   input  logic                            start,
   fir_coef_loader_if.master               axis,
   output logic                            busy,
   output logic                            done,
   output logic                            err
);

   typedef enum logic [1:0] {
      IDLE,
      RELOAD,
      CONFIG,
      DONE
   } state_t;

   localparam logic [C_ADDR_WIDTH-1:0] LAST =
      C_ADDR_WIDTH'(C_NUM_TAPS - 1);

   state_t state;
   state_t state_nx;

   logic [C_ADDR_WIDTH-1:0]         idx;
   logic [C_ADDR_WIDTH-1:0]         idx_nx;
   logic [C_RELOAD_TDATA_WIDTH-1:0] mem [C_NUM_TAPS];

   logic addr_ok;
   logic wr_en;
   logic err_nx;

   assign addr_ok = 32'(cfg_addr) < 32'(C_NUM_TAPS);

   // Reset wins over writes; the buffer itself is never cleared.
   assign wr_en = cfg_we && addr_ok && (state == IDLE) && !areset;

   assign err_nx = (cfg_we && ((state != IDLE) || !addr_ok)) ||
                   (start && (state != IDLE));

   // Coefficient storage, written only while idle.
   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem[cfg_addr] <= cfg_wdata;
      end
   end

   // State, stream index and registered error pulse.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state <= IDLE;
         idx   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         err   <= err_nx;
      end
   end

   // Next state and Moore outputs; tdata is zero whenever tvalid is low.
   always_comb begin
      state_nx                  = state;
      idx_nx                    = idx;
      busy                      = 1'b1;
      done                      = 1'b0;
      axis.m_axis_reload_tvalid = 1'b0;
      axis.m_axis_reload_tlast  = 1'b0;
      axis.m_axis_reload_tdata  = '0;
      axis.m_axis_config_tvalid = 1'b0;
      axis.m_axis_config_tdata  = 8'h00;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nx = RELOAD;
               idx_nx   = '0;
            end
         end
         RELOAD: begin
            axis.m_axis_reload_tvalid = 1'b1;
            axis.m_axis_reload_tdata  = mem[idx];
            axis.m_axis_reload_tlast  = (idx == LAST);
            if (axis.m_axis_reload_tready) begin
               if (idx == LAST) begin
                  state_nx = CONFIG;
                  idx_nx   = '0;
               end else begin
                  idx_nx = idx + C_ADDR_WIDTH'(1);
               end
            end
         end
         CONFIG: begin
            axis.m_axis_config_tvalid = 1'b1;
            if (axis.m_axis_config_tready) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: streaming, stalls, rejected
// requests, config back-pressure and mid-stream reset.
module tb_fir_coef_loader;
   localparam int W = 24;
   localparam int N = 63;
   localparam int A = 6;

   logic         aclk = 1'b0;
   logic         areset;
   logic         cfg_we;
   logic [A-1:0] cfg_addr;
   logic [W-1:0] cfg_wdata;
   logic         start;
   logic         busy;
   logic         done;
   logic         err;

   int total = 0;
   int bad   = 0;

   fir_coef_loader_if #(.W(W)) ax ();

   fir_coef_loader #(
      .C_RELOAD_TDATA_WIDTH(W),
      .C_NUM_TAPS(N),
      .C_ADDR_WIDTH(A)
   ) dut (
      .aclk(aclk),
      .areset(areset),
      .cfg_we(cfg_we),
      .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata),
      .start(start),
      .axis(ax),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_tvalid"}, 32'(ax.m_axis_reload_tvalid), 0);
      chk({tag, "_tlast"}, 32'(ax.m_axis_reload_tlast), 0);
      chk({tag, "_tdata"}, 32'(ax.m_axis_reload_tdata), 0);
      chk({tag, "_cvalid"}, 32'(ax.m_axis_config_tvalid), 0);
      chk({tag, "_cdata"}, 32'(ax.m_axis_config_tdata), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_err"}, 32'(err), 0);
   endtask

   // Full start-to-done run; expects buffer word i to hold i+1.
   task automatic run_stream(input bit toggle, input int cfg_stall,
                             input int again_at);
      int k = 0;
      int ncfg = 0;
      int ndone = 0;
      int hs_cyc = -10;
      bit stalled = 1'b0;
      bit pend_err = 1'b0;
      bit ph = 1'b1;
      logic [W-1:0] hold_d = '0;
      logic hold_l = 1'b0;
      start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      for (int cyc = 0; cyc < 2000 && ndone == 0; cyc++) begin
         chk("err", 32'(err), 32'(pend_err));
         pend_err = 1'b0;
         chk("busy", 32'(busy), 1);
         if (stalled) begin
            chk("stall_valid", 32'(ax.m_axis_reload_tvalid), 1);
            chk("stall_data", 32'(ax.m_axis_reload_tdata), 32'(hold_d));
            chk("stall_last", 32'(ax.m_axis_reload_tlast), 32'(hold_l));
         end
         if (k < N) chk("reload_valid", 32'(ax.m_axis_reload_tvalid), 1);
         if (ax.m_axis_config_tvalid) begin
            chk("cfg_data", 32'(ax.m_axis_config_tdata), 0);
            ncfg++;
         end
         if (done) begin
            ndone++;
            chk("done_lat", cyc, hs_cyc + 1);
         end
         start = 1'b0;
         ax.m_axis_reload_tready = toggle ? ph : 1'b1;
         ph = ~ph;
         stalled = 1'b0;
         if (ax.m_axis_reload_tvalid) begin
            if (ax.m_axis_reload_tready) begin
               chk("word", 32'(ax.m_axis_reload_tdata), k + 1);
               chk("tlast", 32'(ax.m_axis_reload_tlast), 32'(k == N - 1));
               k++;
               if (k == again_at) begin
                  start = 1'b1;
                  pend_err = 1'b1;
               end
            end else begin
               stalled = 1'b1;
               hold_d = ax.m_axis_reload_tdata;
               hold_l = ax.m_axis_reload_tlast;
            end
         end
         ax.m_axis_config_tready = (ncfg > cfg_stall);
         if (ax.m_axis_config_tvalid && ax.m_axis_config_tready)
            hs_cyc = cyc;
         @(negedge aclk);
      end
      start = 1'b0;
      ax.m_axis_reload_tready = 1'b0;
      ax.m_axis_config_tready = 1'b0;
      chk("n_words", k, N);
      chk("n_cfg", ncfg, cfg_stall + 1);
      chk("n_done", ndone, 1);
      chk("post_busy", 32'(busy), 0);
      chk("post_done", 32'(done), 0);
      chk("post_valid", 32'(ax.m_axis_reload_tvalid), 0);
      chk("post_cvalid", 32'(ax.m_axis_config_tvalid), 0);
   endtask

   initial begin
      areset = 1'b1;
      cfg_we = 1'b0;
      cfg_addr = '0;
      cfg_wdata = '0;
      start = 1'b0;
      ax.m_axis_reload_tready = 1'b0;
      ax.m_axis_config_tready = 1'b0;
      repeat (2) @(negedge aclk);
      chk_idle("reset");
      areset = 1'b0;

      for (int i = 0; i < N; i++) begin
         cfg_we = 1'b1;
         cfg_addr = A'(i);
         cfg_wdata = W'(i + 1);
         @(negedge aclk);
      end
      cfg_we = 1'b0;
      chk("load_err", 32'(err), 0);

      run_stream(1'b0, 0, 0);
      run_stream(1'b1, 0, 0);

      cfg_we = 1'b1;
      cfg_addr = 6'd63;
      cfg_wdata = 24'hABCDEF;
      @(negedge aclk);
      cfg_we = 1'b0;
      chk("oob_err", 32'(err), 1);
      @(negedge aclk);
      chk("oob_err_end", 32'(err), 0);

      run_stream(1'b0, 5, 10);

      start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      ax.m_axis_reload_tready = 1'b1;
      for (int j = 0; j < 20; j++) begin
         chk("abort_word", 32'(ax.m_axis_reload_tdata), j + 1);
         if (j == 6) begin
            chk("busy_we_err", 32'(err), 1);
            cfg_we = 1'b0;
         end
         if (j == 5) begin
            cfg_we = 1'b1;
            cfg_addr = '0;
            cfg_wdata = 24'h777777;
         end
         @(negedge aclk);
      end
      areset = 1'b1;
      start = 1'b1;
      cfg_we = 1'b1;
      cfg_addr = '0;
      cfg_wdata = 24'h555555;
      @(negedge aclk);
      areset = 1'b0;
      start = 1'b0;
      cfg_we = 1'b0;
      ax.m_axis_reload_tready = 1'b0;
      chk_idle("abort");
      for (int j = 0; j < 3; j++) begin
         @(negedge aclk);
         chk("abort_no_done", 32'(done), 0);
         chk("abort_idle", 32'(busy), 0);
      end

      run_stream(1'b0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fir_coef_loader.md
FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 The module SHALL have parameter C_RELOAD_TDATA_WIDTH, default 24, coefficient word width.
REQ-002 The module SHALL have parameter C_NUM_TAPS, default 63, number of coefficients per reload packet (range 2..256).
REQ-003 The module SHALL have parameter C_ADDR_WIDTH, default 6, coefficient buffer address width; 2**C_ADDR_WIDTH >= C_NUM_TAPS.
REQ-004 The module SHALL use one clock and a synchronous active-high reset, with ports as follows.
REQ-005 aclk  in  1  rising-edge clock for all logic.
REQ-006 areset  in  1  synchronous active-high reset.
REQ-007 cfg_we  in  1  coefficient buffer write strobe.
REQ-008 cfg_addr  in  C_ADDR_WIDTH  coefficient index to write.
REQ-009 cfg_wdata  in  C_RELOAD_TDATA_WIDTH  coefficient value.
REQ-010 start  in  1  single-cycle request to stream the buffer into the FIR.
REQ-011 m_axis_reload_tvalid / tready / tlast  out/in/out  1 each  AXI-Stream reload channel to the FIR s_axis_reload port.
REQ-012 m_axis_reload_tdata  out  C_RELOAD_TDATA_WIDTH  coefficient being sent.
REQ-013 m_axis_config_tvalid  out  1, m_axis_config_tready  in  1, m_axis_config_tdata  out  8: config packet that commits the reloaded set.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse on completion.
REQ-016 err  out  1  one-cycle pulse on a rejected write or start.

Function
REQ-017 The buffer SHALL hold C_NUM_TAPS words; a write is performed when cfg_we=1, state=IDLE and cfg_addr<C_NUM_TAPS.
REQ-018 cfg_we with cfg_addr>=C_NUM_TAPS, or cfg_we outside IDLE, SHALL leave the buffer unchanged and pulse err the next cycle.
REQ-019 FSM states SHALL be IDLE, RELOAD, CONFIG, DONE.
REQ-020 IDLE->RELOAD on start=1; idx cleared to 0; m_axis_reload_tvalid=1 with tdata=buf[0] on the following cycle (1-cycle latency).
REQ-021 start while not in IDLE SHALL be ignored and pulse err the next cycle; start with simultaneous cfg_we in IDLE SHALL perform the write and start, streaming the written value if idx matches.
REQ-022 In RELOAD a transfer occurs on tvalid&&tready; idx increments by 1 and tdata becomes buf[idx+1] on the next cycle.
REQ-023 tdata, tlast and tvalid SHALL remain stable while tvalid=1 and tready=0.
REQ-024 tlast SHALL be 1 exactly when idx=C_NUM_TAPS-1; transfer of that word moves RELOAD->CONFIG; tvalid deasserts the next cycle.
REQ-025 In CONFIG, m_axis_config_tvalid=1 and m_axis_config_tdata=8'h00, held until m_axis_config_tready=1; that handshake moves to DONE.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 Exactly C_NUM_TAPS reload transfers and one config transfer SHALL occur per start.
REQ-028 A tready held low indefinitely SHALL stall the FSM with no timeout.

Reset
REQ-029 areset=1 SHALL on the next edge force IDLE, idx=0, and all outputs to 0 (tvalid, tlast, tdata, config tvalid/tdata, busy, done, err).
REQ-030 areset SHALL NOT alter buffer contents; reset mid-RELOAD SHALL abort without done, and a later start SHALL restart from buf[0].
REQ-031 areset SHALL take priority over start and cfg_we in the same cycle.

Verification
REQ-032 Write buf[i]=i+1 for i=0..62, pulse start, tready=1 -> 63 words 0x000001..0x00003F on consecutive cycles, tlast only on 0x00003F, then config 0x00, done pulse, busy low.
REQ-033 Same load, tready toggling 1/0 each cycle -> identical 63-word sequence, tdata/tlast stable during every stall cycle.
REQ-034 cfg_we with cfg_addr=63 -> err pulse, buffer unchanged (verified by subsequent stream).
REQ-035 start pulsed again at word 10 of a stream -> err pulse, stream continues unchanged to 63 words and single done.
REQ-036 areset asserted after word 20 -> all outputs 0 next cycle, no done; new start -> stream restarts at 0x000001.
REQ-037 m_axis_config_tready held low 5 cycles -> config_tvalid held 5+1 cycles, done one cycle after handshake.
